// File: rtl/fetch_pkg.sv
// Shared types and AXI constants for the instruction fetch unit.
// FETCH_LINEBUF_EN selects the 32-byte line buffer over single-beat fetch.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    RESP,
    DRAIN
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         LINE_BYTES     = 32;

endpackage

// File: rtl/fetch_linebuf.sv
// Beat storage, line tag, valid bit and hit compare for the fetch unit.
// FETCH_LINEBUF_EN: full line; otherwise one registered beat, never hits.
module fetch_linebuf
  import fetch_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int CW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [31:0]   lookup_pc,
  input  logic [31:0]   rd_pc,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_idx,
  input  logic [63:0]   wr_data,
  input  logic          fill_done,
  input  logic          fill_ok,
  output logic          hit,
  output logic [31:0]   word
);

  logic [63:0] beat;

`ifdef FETCH_LINEBUF_EN
  localparam int OFF = $clog2(LINE_BYTES);

  logic [63:0]     beats [LINE_BEATS];
  logic [31-OFF:0] tag;
  logic            line_valid;
  logic            unused;

  always_ff @(posedge clk) begin
    if (wr_en) beats[wr_idx] <= wr_data;
  end

  // flush wins over a fill completing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= 1'b0;
      tag        <= '0;
    end else if (flush) begin
      line_valid <= 1'b0;
    end else if (fill_done) begin
      line_valid <= fill_ok;
      tag        <= rd_pc[31:OFF];
    end
  end

  assign hit    = line_valid && (tag == lookup_pc[31:OFF]);
  assign beat   = beats[rd_pc[3 +: CW]];
  assign unused = ^{lookup_pc[OFF-1:0], rd_pc[1:0]};
`else
  logic unused;

  always_ff @(posedge clk) begin
    if (rst)        beat <= '0;
    else if (wr_en) beat <= wr_data;
  end

  assign hit    = 1'b0;
  assign unused = ^{flush, lookup_pc, rd_pc[31:3], rd_pc[1:0],
                    wr_idx, fill_done, fill_ok};
`endif

  assign word = rd_pc[2] ? beat[63:32] : beat[31:0];

endmodule

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: pc request in, 32-bit instruction out, AXI4 reads.
// FETCH_LINEBUF_EN enables line refill and hits; default fetches one beat.
module ifu_axi_fetch
  import fetch_pkg::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic [31:0] pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready
);

  localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  state_t        state;
  state_t        nxt;
  logic [31:0]   pc_q;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          drop_q;
  logic          hit;
  logic          last_beat;
  logic          fill_ok;
  logic [31:0]   word;

  assign last_beat = (state == R) && rvalid && rlast;
  assign fill_ok   = (cnt == CW'(LINE_BEATS - 1)) && !err_q
                     && (rresp == AXI_RESP_OKAY);

  fetch_linebuf #(
    .LINE_BEATS(LINE_BEATS),
    .CW        (CW)
  ) u_linebuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .lookup_pc(pc),
    .rd_pc    (pc_q),
    .wr_en    ((state == R) && rvalid),
    .wr_idx   (cnt),
    .wr_data  (rdata),
    .fill_done(last_beat),
    .fill_ok  (fill_ok),
    .hit      (hit),
    .word     (word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // a burst ending together with flush has nothing left to drain
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (flush)         nxt = IDLE;
        else if (pc_valid) nxt = hit ? RESP : AR;
      end
      AR: begin
        if (arready) nxt = (flush || drop_q) ? DRAIN : R;
      end
      R: begin
        if (rvalid && rlast) nxt = flush ? IDLE : RESP;
        else if (flush)      nxt = DRAIN;
      end
      RESP: begin
        if (flush || inst_ready) nxt = IDLE;
      end
      DRAIN: begin
        if (rvalid && rlast) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (pc_valid && pc_ready) pc_q <= pc;
      drop_q <= (state == AR) && !arready && (drop_q || flush);
      if (state == AR) begin
        cnt   <= '0;
        err_q <= 1'b0;
      end else if ((state == R) && rvalid) begin
        cnt <= cnt + 1'b1;
        if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    pc_ready   = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:     pc_ready   = !flush;
        AR:       arvalid    = 1'b1;
        R, DRAIN: rready     = 1'b1;
        RESP:     inst_valid = !flush;
        default:  ;
      endcase
    end
  end

  assign inst    = inst_valid ? word : '0;
  assign arsize  = AXI_SIZE_8B;
  assign arburst = AXI_BURST_INCR;

`ifdef FETCH_LINEBUF_EN
  assign araddr = {pc_q[31:5], 5'b0};
  assign arlen  = 8'(LINE_BEATS - 1);
`else
  assign araddr = {pc_q[31:3], 3'b0};
  assign arlen  = 8'd0;
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Bench for ifu_axi_fetch: vector table, corner sequences, random fetches
// against a memory/line model and a randomly stalling AXI slave.
module tb_ifu_axi_fetch;

`ifdef FETCH_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  localparam int BEATS = 4;

  logic        clk;
  logic        rst;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        flush;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready;

  ifu_axi_fetch #(.LINE_BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .pc        (pc),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_ready(inst_ready),
    .flush     (flush),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rlast     (rlast),
    .rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // slave bookkeeping
  int          ar_cnt = 0;
  int          beats_left = 0;
  int          bidx = 0;
  int          err_beat = -1;
  int          retract = 0;
  time         rlast_time = 0;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;
  logic [4:0]  last_szb = '0;
  logic [31:0] baddr = '0;

  // line model
  bit          lv = 1'b0;
  logic [26:0] mt = '0;

  function automatic logic [63:0] mem64(input logic [31:0] a);
    return {a ^ 32'h5A5A_0004, a ^ 32'hC3C3_0000};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [63:0] b;
    b = mem64({a[31:3], 3'b000});
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI read slave: random arready / rvalid gaps, optional error beat
  initial begin
    bit fired;
    bit prev_arv;
    bit prev_hs;
    fired = 1'b0;
    prev_arv = 1'b0;
    prev_hs = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        beats_left = 0;
        bidx = 0;
        fired = 1'b0;
        prev_arv = 1'b0;
        prev_hs = 1'b0;
        continue;
      end
      if (prev_arv && !prev_hs && !arvalid) retract++;
      if (beats_left == 0) rvalid = 1'b0;
      else if (fired || !rvalid) rvalid = ($urandom_range(3) != 0);
      rdata = mem64(baddr + 32'(8 * bidx));
      rlast = (beats_left == 1);
      rresp = (bidx == err_beat) ? 2'b10 : 2'b00;
      fired = rvalid && rready;
      if (fired) begin
        if (rlast) rlast_time = $time;
        beats_left--;
        bidx++;
      end
      arready = (beats_left == 0) && ($urandom_range(1) == 1);
      prev_arv = arvalid;
      prev_hs = arvalid && arready;
      if (prev_hs) begin
        ar_cnt++;
        last_araddr = araddr;
        last_arlen = arlen;
        last_szb = {arsize, arburst};
        beats_left = int'(arlen) + 1;
        bidx = 0;
        baddr = araddr;
      end
    end
  end

  task automatic issue(input logic [31:0] a, output time t_acc);
    int n;
    n = 0;
    @(negedge clk);
    pc_valid = 1'b1;
    pc = a;
    while (!pc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("pc_accept_timeout", 32'(n), 32'd0);
    t_acc = $time;
    @(negedge clk);
    pc_valid = 1'b0;
    pc = $urandom;
  endtask

  task automatic collect(input int hold, input bit miss, input time t_acc,
                         input logic [31:0] exp_inst, input string tag);
    int n;
    bit ok;
    time t_iv;
    logic [31:0] d0;
    n = 0;
    ok = 1'b1;
    while (!inst_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk({tag, "_inst_timeout"}, 32'(n), 32'd0);
      return;
    end
    t_iv = $time;
    if (miss) chk({tag, "_miss_lat"}, 32'(t_iv - rlast_time), 32'd9);
    else      chk({tag, "_hit_lat"}, 32'(t_iv - t_acc), 32'd10);
    d0 = inst;
    repeat (hold) begin
      @(negedge clk);
      if (!inst_valid || inst !== d0 || pc_ready) ok = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(ok), 32'd1);
    chk({tag, "_inst"}, inst, exp_inst);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk({tag, "_done"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic model_after(input logic [31:0] a, input bit miss,
                             input int err);
    if (miss) begin
      lv = LB && (err < 0);
      mt = a[31:5];
    end
  endtask

  task automatic fetch_chk(input logic [31:0] a, input int err, input int hold,
                           input bit exp_ar, input logic [31:0] exp_addr,
                           input logic [7:0] exp_len,
                           input logic [31:0] exp_inst, input string tag);
    time t;
    int ar0;
    err_beat = err;
    ar0 = ar_cnt;
    issue(a, t);
    collect(hold, exp_ar, t, exp_inst, tag);
    chk({tag, "_ar_count"}, 32'(ar_cnt - ar0), 32'(exp_ar));
    if (exp_ar) begin
      chk({tag, "_araddr"}, last_araddr, exp_addr);
      chk({tag, "_arlen"}, 32'(last_arlen), 32'(exp_len));
      chk({tag, "_size_burst"}, 32'(last_szb), 32'(5'b011_01));
    end
    model_after(a, exp_ar, err);
  endtask

  task automatic mfetch(input logic [31:0] a, input int err, input int hold,
                        input string tag);
    bit miss;
    logic [31:0] addr;
    miss = !(LB && lv && mt == a[31:5]);
    addr = LB ? {a[31:5], 5'b0} : {a[31:3], 3'b0};
    fetch_chk(a, err, hold, miss, addr, LB ? 8'd3 : 8'd0, exp_word(a), tag);
  endtask

  task automatic drain_chk(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!(pc_ready && beats_left == 0) && n < 100) begin
      @(negedge clk);
      seen |= inst_valid;
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n >= 100), 32'd0);
    chk({tag, "_no_inst"}, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          err;
    int          hold;
    bit          ar;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[6];

  initial begin
    time t;
    int ar0;
    int n;
    logic [31:0] a;
    int err;

`ifdef FETCH_LINEBUF_EN
    tbl[0] = '{32'h8000_0004, -1, 0, 1'b1, 32'h8000_0000, 8'd3,
               exp_word(32'h8000_0004)};
    tbl[1] = '{32'h8000_0018, -1, 0, 1'b0, 32'h0, 8'd0,
               exp_word(32'h8000_0018)};
    tbl[2] = '{32'h8000_001C, -1, 5, 1'b0, 32'h0, 8'd0,
               exp_word(32'h8000_001C)};
    tbl[3] = '{32'h8000_0040, 2, 1, 1'b1, 32'h8000_0040, 8'd3,
               exp_word(32'h8000_0040)};
    tbl[4] = '{32'h8000_0044, -1, 0, 1'b1, 32'h8000_0040, 8'd3,
               exp_word(32'h8000_0044)};
    tbl[5] = '{32'h8000_0048, -1, 0, 1'b0, 32'h0, 8'd0,
               exp_word(32'h8000_0048)};
`else
    tbl[0] = '{32'h8000_0004, -1, 0, 1'b1, 32'h8000_0000, 8'd0,
               exp_word(32'h8000_0004)};
    tbl[1] = '{32'h8000_0004, -1, 5, 1'b1, 32'h8000_0000, 8'd0,
               exp_word(32'h8000_0004)};
    tbl[2] = '{32'h8000_0018, -1, 0, 1'b1, 32'h8000_0018, 8'd0,
               exp_word(32'h8000_0018)};
    tbl[3] = '{32'h8000_001C, 0, 1, 1'b1, 32'h8000_0018, 8'd0,
               exp_word(32'h8000_001C)};
    tbl[4] = '{32'h8000_0040, -1, 0, 1'b1, 32'h8000_0040, 8'd0,
               exp_word(32'h8000_0040)};
    tbl[5] = '{32'h8000_0044, -1, 0, 1'b1, 32'h8000_0040, 8'd0,
               exp_word(32'h8000_0044)};
`endif

    rst = 1'b1;
    pc_valid = 1'b0;
    pc = '0;
    inst_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc_ready", 32'(pc_ready), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_pc_ready", 32'(pc_ready), 32'd1);

    foreach (tbl[i])
      fetch_chk(tbl[i].pc, tbl[i].err, tbl[i].hold, tbl[i].ar, tbl[i].addr,
                tbl[i].len, tbl[i].inst, $sformatf("vec%0d", i));

    // flush while the address phase is outstanding
    err_beat = -1;
    ar0 = ar_cnt;
    issue(32'h8000_0200, t);
    chk("fa_arvalid", 32'(arvalid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drain_chk("fa");
    chk("fa_ar_count", 32'(ar_cnt - ar0), 32'd1);
    lv = 1'b0;

    // flush mid-burst after two beats, then the old line must refetch
    mfetch(32'h8000_0000, -1, 0, "fr_fill");
    mfetch(32'h8000_0004, -1, 0, "fr_pre");
    issue(32'h8000_0100, t);
    n = 0;
    while (!(rready && (!LB || bidx >= 2)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fr_wait_timeout", 32'(n >= 100), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drain_chk("fr");
    lv = 1'b0;
    mfetch(32'h8000_0000, -1, 0, "fr_refetch");

    // reset in the middle of a burst
    issue(32'h8000_0300, t);
    n = 0;
    while (!rready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rm_wait_timeout", 32'(n >= 100), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_arvalid", 32'(arvalid), 32'd0);
    chk("rm_rready", 32'(rready), 32'd0);
    chk("rm_inst_valid", 32'(inst_valid), 32'd0);
    chk("rm_pc_ready", 32'(pc_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rm_pc_ready_after", 32'(pc_ready), 32'd1);
    lv = 1'b0;
    mfetch(32'h8000_0300, -1, 0, "rm_refetch");

    for (int i = 0; i < 120; i++) begin
      a = 32'h8000_0000 + 32'($urandom_range(3) * 32)
          + 32'($urandom_range(7) * 4);
      err = ($urandom_range(7) == 0) ? $urandom_range(LB ? 3 : 0) : -1;
      mfetch(a, err, $urandom_range(2), $sformatf("rnd%0d", i));
    end

    chk("ar_retract", 32'(retract), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifu_axi_fetch.md
IFU_AXI_FETCH -- requirements
Module: ifu_axi_fetch

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, giving the number of 64-bit beats per line (line = 32 bytes).
REQ-002 SHALL have port clk, input, 1: clock; reset rst, synchronous, active-high.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-004 SHALL have port pc_valid, input, 1: fetch request valid.
REQ-005 SHALL have port pc_ready, output, 1: fetch request accepted.
REQ-006 SHALL have port pc, input, 32: fetch byte address, 4-byte aligned.
REQ-007 SHALL have port inst_valid, output, 1: instruction valid.
REQ-008 SHALL have port inst, output, 32: fetched instruction.
REQ-009 SHALL have port inst_ready, input, 1: consumer accepts inst.
REQ-010 SHALL have port flush, input, 1: drop in-flight fetch, invalidate line.
REQ-011 SHALL have AXI read-address ports araddr (output, 32), arvalid (output, 1), arready (input, 1), arlen (output, 8), arsize (output, 3), arburst (output, 2).
REQ-012 SHALL have AXI read-data ports rdata (input, 64), rresp (input, 2), rvalid (input, 1), rlast (input, 1), rready (output, 1).

Function
REQ-013 SHALL implement states IDLE, AR, R, RESP, DRAIN.
REQ-014 IDLE: pc_ready=1 unless flush; pc_valid&pc_ready latches pc; line hit (line_valid & tag==pc[31:5]) -> RESP; miss -> AR.
REQ-015 Hit latency SHALL be 1 cycle: pc accepted in cycle N, inst_valid high in N+1.
REQ-016 AR: arvalid=1, araddr={pc_q[31:5],5'b0}, arburst=2'b01 (INCR), arsize=3'b011, arlen=LINE_BEATS-1; arready -> R.
REQ-017 arlen/arsize/arburst SHALL be constant from AR entry until the rlast beat completes, because the slave compares beats against live arlen.
REQ-018 R: rready=1; each rvalid beat writes buffer[cnt], cnt increments (width clog2(LINE_BEATS)); rvalid&rlast -> RESP, tag<=pc_q[31:5].
REQ-019 line_valid SHALL be set at rlast only if cnt==LINE_BEATS-1 and every beat had rresp==2'b00; otherwise it stays 0, and the instruction is still returned.
REQ-020 RESP: inst_valid=1, inst=buffer[pc_q[4:3]][32*pc_q[2] +: 32]; inst held stable until inst_ready; inst_valid&inst_ready -> IDLE.
REQ-021 Miss latency SHALL be: inst_valid asserted the cycle after the rlast handshake.
REQ-022 flush SHALL clear line_valid and have priority over every other event in the same cycle.
REQ-023 flush in IDLE/RESP -> IDLE, with the pending inst dropped.
REQ-024 flush in AR: arvalid SHALL stay high (no retraction) until arready, then the block goes to DRAIN.
REQ-025 flush in R: next state DRAIN.
REQ-026 DRAIN: rready=1, data discarded; rvalid&rlast -> IDLE; no inst_valid.
REQ-027 pc_ready SHALL be 0 in every state except IDLE.

Reset
REQ-028 While rst is high, the block SHALL drive state=IDLE, line_valid=0, cnt=0, arvalid=0, rready=0, inst_valid=0, inst=0, pc_ready=0; after rst, pc_ready=1 from the first cycle.
REQ-029 rst mid-burst SHALL abandon the burst without draining; the slave is reset by the same rst.

Configuration
REQ-030 Macro FETCH_LINEBUF_EN defined: line-buffer behaviour as above.
REQ-031 Macro FETCH_LINEBUF_EN undefined: no buffer/tag; every fetch misses; arlen=0, araddr={pc_q[31:3],3'b0}; the single beat is registered; inst=beat[32*pc_q[2] +: 32].

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, AXI_BURST_INCR, AXI_SIZE_8B, AXI_RESP_OKAY and LINE_BYTES.
REQ-033 Sub-module fetch_linebuf SHALL hold beat storage, tag, line_valid, and the hit compare.

Verification
REQ-034 Cold miss: pc=0x80000004 -> araddr=0x80000000, arlen=3, 4 beats; inst=beat0[63:32]; inst_valid the cycle after rlast.
REQ-035 Hit: after REQ-034, pc=0x80000018 -> no AR, inst=beat3[31:0] one cycle after acceptance.
REQ-036 Backpressure: inst_ready low 5 cycles in RESP -> inst stable; pc_ready low throughout.
REQ-037 Flush in R after beat1 -> remaining beats drained, no inst_valid, next pc=0x80000000 misses.
REQ-038 Error: rresp=2'b10 on beat2 -> inst returned, line_valid=0, refetch of the same line issues AR.
REQ-039 Without FETCH_LINEBUF_EN: pc=0x80000004 twice -> two AR with arlen=0, araddr=0x80000000.
